// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: merges single-cycle ALU results and FIFO-buffered load returns
// into one register file write per cycle, tracks pending loads, bounds load starvation.
// Optional SCALAR_WB_FWD_EN adds a same-cycle write-to-read forwarding side channel.
module scalar_wb_arbiter #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  output logic              Swren,
  output logic [AW-1:0]     Swraddr,
  output logic [DW-1:0]     Swrdata,
  output logic [2**AW-1:0]  pend
`ifdef SCALAR_WB_FWD_EN
  ,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DW-1:0]     fwd_data
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NR = 2**AW;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [NR-1:0] pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          empty, full, push, pop;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign ld_ready = !full;
  assign push     = ld_valid && !full;
  // ALU always has priority; the FIFO only drains in ALU-idle cycles.
  assign pop      = !alu_valid && !empty;

  assign wr_sel  = alu_valid || !empty;
  assign wr_addr = alu_valid ? alu_addr : fifo_addr_q[rd_ptr_q];
  assign wr_data = alu_valid ? alu_data : fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    starve_d = starve_q;
    wren_d   = wr_sel;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Clear before set so a same-address push during the pop keeps the bit high.
    if (pop)  pend_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
    if (push) pend_d[ld_addr] = 1'b1;

    // Non-empty without a pop means the ALU took the port from a waiting load.
    if (pop || empty)                         starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))     starve_d = starve_q + SW'(1);

    if (wr_sel) begin
      waddr_d = wr_addr;
      wdata_d = wr_data;
    end
  end

  assign stall_d = (starve_d == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Payload storage needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ld_addr;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign alu_stall = stall_q;
  assign Swren     = wren_q;
  assign Swraddr   = waddr_q;
  assign Swrdata   = wdata_q;
  assign pend      = pend_q;

`ifdef SCALAR_WB_FWD_EN
  logic          fwd_a_q, fwd_b_q;
  logic [DW-1:0] fwd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q    <= 1'b0;
      fwd_b_q    <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_a_q    <= wr_sel && (wr_addr == rd_addr_a);
      fwd_b_q    <= wr_sel && (wr_addr == rd_addr_b);
      fwd_data_q <= wr_data;
    end
  end

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign fwd_data = fwd_data_q;
`endif

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Randomized and directed bench for scalar_wb_arbiter against a queue-based reference model.
module tb_scalar_wb_arbiter;

  localparam int unsigned DW         = 16;
  localparam int unsigned AW         = 3;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned NR         = 2**AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_stall;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          Swren;
  logic [AW-1:0] Swraddr;
  logic [DW-1:0] Swrdata;
  logic [NR-1:0] pend;
`ifdef SCALAR_WB_FWD_EN
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          fwd_a, fwd_b;
  logic [DW-1:0] fwd_data;
  logic          m_fa, m_fb;
  logic [DW-1:0] m_fdata;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t          q[$];
  int            m_cnt;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_stall;

  scalar_wb_arbiter #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .Swren     (Swren),
    .Swraddr   (Swraddr),
    .Swrdata   (Swrdata),
    .pend      (pend)
`ifdef SCALAR_WB_FWD_EN
    ,
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] model_pend();
    logic [NR-1:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    return p;
  endfunction

  function automatic bit in_queue(input logic [AW-1:0] a);
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_wen = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_stall = 1'b0;
`ifdef SCALAR_WB_FWD_EN
    m_fa = 1'b0;
    m_fb = 1'b0;
    m_fdata = '0;
`endif
  endtask

  // One clock cycle: drive, predict, clock, compare DUT against the model.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    int   n0;
    logic rdy;
    ent_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ld;
    #1;
    n0  = q.size();
    rdy = (n0 < DEPTH);
    checks++;
    if (ld_ready !== rdy) begin
      errors++;
      $display("FAIL ld_ready: got %b want %b (t=%0t)", ld_ready, rdy, $time);
    end
    if (av) begin
      m_wen = 1'b1; m_waddr = aa; m_wdata = ad;
    end else if (n0 > 0) begin
      e = q.pop_front();
      m_wen = 1'b1; m_waddr = e.a; m_wdata = e.d;
    end else begin
      m_wen = 1'b0;
    end
`ifdef SCALAR_WB_FWD_EN
    m_fa = m_wen && (m_waddr == rd_addr_a);
    m_fb = m_wen && (m_waddr == rd_addr_b);
    m_fdata = m_wdata;
`endif
    if (n0 == 0 || !av) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt++;
    m_stall = (m_cnt == STARVE_MAX);
    if (lv && rdy) begin
      e.a = la; e.d = ld;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    checks += 5;
    if (Swren !== m_wen) begin
      errors++; $display("FAIL Swren: got %b want %b (t=%0t)", Swren, m_wen, $time);
    end
    if (Swraddr !== m_waddr) begin
      errors++; $display("FAIL Swraddr: got %0d want %0d (t=%0t)", Swraddr, m_waddr, $time);
    end
    if (Swrdata !== m_wdata) begin
      errors++; $display("FAIL Swrdata: got %h want %h (t=%0t)", Swrdata, m_wdata, $time);
    end
    if (pend !== model_pend()) begin
      errors++; $display("FAIL pend: got %b want %b (t=%0t)", pend, model_pend(), $time);
    end
    if (alu_stall !== m_stall) begin
      errors++; $display("FAIL alu_stall: got %b want %b (t=%0t)", alu_stall, m_stall, $time);
    end
`ifdef SCALAR_WB_FWD_EN
    checks += 2;
    if (fwd_a !== m_fa || fwd_b !== m_fb) begin
      errors++; $display("FAIL fwd_ab: got %b%b want %b%b", fwd_a, fwd_b, m_fa, m_fb);
    end
    if ((m_fa || m_fb) && fwd_data !== m_fdata) begin
      errors++; $display("FAIL fwd_data: got %h want %h", fwd_data, m_fdata);
    end
`endif
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks += 6;
    if (Swren !== 1'b0)   begin errors++; $display("FAIL rst_Swren: got %b want 0", Swren); end
    if (Swraddr !== '0)   begin errors++; $display("FAIL rst_Swraddr: got %0d want 0", Swraddr); end
    if (Swrdata !== '0)   begin errors++; $display("FAIL rst_Swrdata: got %h want 0", Swrdata); end
    if (pend !== '0)      begin errors++; $display("FAIL rst_pend: got %b want 0", pend); end
    if (alu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", alu_stall); end
    if (ld_ready !== 1'b1)  begin errors++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_only();
    step(1'b1, 3'd3, 16'hABCD, 1'b0, '0, '0);
    checks++;
    if (Swren !== 1'b1 || Swraddr !== 3'd3 || Swrdata !== 16'hABCD) begin
      errors++;
      $display("FAIL alu_write: got %b/%0d/%h want 1/3/abcd", Swren, Swraddr, Swrdata);
    end
    idle();
    checks++;
    if (Swren !== 1'b0) begin errors++; $display("FAIL alu_idle: got %b want 0", Swren); end
  endtask

  task automatic test_load_path();
    step(1'b0, '0, '0, 1'b1, 3'd5, 16'h1234);
    checks++;
    if (pend[5] !== 1'b1 || Swren !== 1'b0) begin
      errors++; $display("FAIL ld_push: got pend5=%b Swren=%b want 1/0", pend[5], Swren);
    end
    idle();
    checks++;
    if (Swren !== 1'b1 || Swraddr !== 3'd5 || Swrdata !== 16'h1234 || pend[5] !== 1'b0) begin
      errors++;
      $display("FAIL ld_wb: got %b/%0d/%h pend5=%b want 1/5/1234/0", Swren, Swraddr, Swrdata,
               pend[5]);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd7, DW'(i), 1'b1, AW'(i), 16'hA000 + DW'(i));
      if (i == 3) begin
        checks++;
        if (ld_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready: got %b want 0", ld_ready);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++;
      if (Swren !== 1'b1 || Swraddr !== AW'(i) || Swrdata !== 16'hA000 + DW'(i)) begin
        errors++;
        $display("FAIL full_drain%0d: got %b/%0d/%h want 1/%0d/%h", i, Swren, Swraddr, Swrdata,
                 i, 16'hA000 + DW'(i));
      end
    end
    idle();
    checks++;
    if (Swren !== 1'b0) begin errors++; $display("FAIL full_extra: got %b want 0", Swren); end
  endtask

  task automatic test_starvation();
    step(1'b1, 3'd1, 16'h0000, 1'b1, 3'd2, 16'h5A5A);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 3'd1, DW'(k), 1'b0, '0, '0);
      if (k == 7 || k == 8) begin
        checks++;
        if (alu_stall !== (k == 8)) begin
          errors++; $display("FAIL starve_k%0d: got %b want %b", k, alu_stall, k == 8);
        end
      end
    end
    step(1'b1, 3'd1, 16'hBEEF, 1'b0, '0, '0);
    checks++;
    if (alu_stall !== 1'b1 || Swrdata !== 16'hBEEF) begin
      errors++; $display("FAIL starve_hold: got %b/%h want 1/beef", alu_stall, Swrdata);
    end
    idle();
    checks++;
    if (Swren !== 1'b1 || Swraddr !== 3'd2 || Swrdata !== 16'h5A5A || alu_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_release: got %b/%0d/%h stall=%b want 1/2/5a5a/0", Swren, Swraddr,
               Swrdata, alu_stall);
    end
  endtask

  task automatic test_set_wins();
    step(1'b0, '0, '0, 1'b1, 3'd6, 16'h1111);
    step(1'b0, '0, '0, 1'b1, 3'd6, 16'h2222);
    checks++;
    if (Swrdata !== 16'h1111 || pend[6] !== 1'b1) begin
      errors++; $display("FAIL set_wins: got %h pend6=%b want 1111/1", Swrdata, pend[6]);
    end
    idle();
    checks++;
    if (Swrdata !== 16'h2222 || pend[6] !== 1'b0) begin
      errors++; $display("FAIL set_wins_drain: got %h pend6=%b want 2222/0", Swrdata, pend[6]);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, DW'(i), 1'b1, AW'(i + 1), 16'hC000 + DW'(i));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (Swren !== 1'b0 || pend !== '0 || ld_ready !== 1'b1 || alu_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got Swren=%b pend=%b rdy=%b stall=%b want 0/0/1/0", Swren, pend,
               ld_ready, alu_stall);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();
  endtask

`ifdef SCALAR_WB_FWD_EN
  task automatic test_fwd();
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd4;
    step(1'b1, 3'd2, 16'h00FF, 1'b0, '0, '0);
    checks++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0 || fwd_data !== 16'h00FF) begin
      errors++; $display("FAIL fwd: got %b%b/%h want 10/00ff", fwd_a, fwd_b, fwd_data);
    end
  endtask
`endif

  task automatic test_random();
    logic          av, lv;
    logic [AW-1:0] la;
    for (int n = 0; n < 600; n++) begin
      av = !m_stall && ($urandom_range(0, 99) < 55);
      lv = ($urandom_range(0, 99) < 50);
      la = AW'($urandom);
      for (int t = 0; t < 8 && in_queue(la); t++) la = AW'($urandom);
      if (in_queue(la)) lv = 1'b0;
`ifdef SCALAR_WB_FWD_EN
      rd_addr_a = AW'($urandom);
      rd_addr_b = AW'($urandom);
`endif
      step(av, AW'($urandom), DW'($urandom), lv, la, DW'($urandom));
    end
    for (int n = 0; n < DEPTH + 2; n++) idle();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load_path();
    test_full();
    test_starvation();
    test_set_wins();
    test_reset_mid_run();
`ifdef SCALAR_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
